// File: rtl/set_point_counter.sv
// Counts lattice points (x,y) in 1..GRID_SIZE that lie inside or on a circle.
// Define SET_FAST_SCAN_EN to evaluate a whole column per cycle instead of one point.
module set_point_counter #(
    parameter int GRID_SIZE = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [7:0] central,
    input  logic [3:0] radius,
    output logic       busy,
    output logic       valid,
    output logic [7:0] candidate
);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    localparam logic [3:0] LAST = 4'(GRID_SIZE);

    state_t     r_state;
    logic [3:0] r_xc;
    logic [3:0] r_yc;
    logic [3:0] r_r;
    logic [3:0] r_x;
    logic [7:0] r_acc;
    logic [7:0] r_hit;
    logic       r_flush;
    logic [7:0] w_hit;

    function automatic logic in_circle(input logic [3:0] x, input logic [3:0] y,
                                       input logic [3:0] xc, input logic [3:0] yc,
                                       input logic [3:0] r);
        logic signed [4:0] dx;
        logic signed [4:0] dy;
        logic [4:0]        mx;
        logic [4:0]        my;
        logic [7:0]        sx;
        logic [7:0]        sy;
        logic [8:0]        sum;
        logic [7:0]        r2;
        dx  = $signed({1'b0, x}) - $signed({1'b0, xc});
        dy  = $signed({1'b0, y}) - $signed({1'b0, yc});
        mx  = (dx < 0) ? 5'(-dx) : 5'(dx);
        my  = (dy < 0) ? 5'(-dy) : 5'(dy);
        sx  = {4'b0, mx[3:0]} * {4'b0, mx[3:0]};
        sy  = {4'b0, my[3:0]} * {4'b0, my[3:0]};
        sum = {1'b0, sx} + {1'b0, sy};
        r2  = {4'b0, r} * {4'b0, r};
        return sum <= {1'b0, r2};
    endfunction

`ifdef SET_FAST_SCAN_EN
    logic [GRID_SIZE-1:0] w_col;

    generate
        for (genvar gi = 0; gi < GRID_SIZE; gi++) begin : g_col
            assign w_col[gi] = in_circle(r_x, 4'(gi + 1), r_xc, r_yc, r_r);
        end
    endgenerate

    always_comb begin
        w_hit = '0;
        for (int i = 0; i < GRID_SIZE; i++) begin
            w_hit = w_hit + {7'b0, w_col[i]};
        end
    end
`else
    logic [3:0] r_y;

    assign w_hit = {7'b0, in_circle(r_x, r_y, r_xc, r_yc, r_r)};
`endif

    // Comparator result is registered, so the accumulator trails the scan by one
    // cycle; r_flush marks the extra CALC cycle that folds in the final hit.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state   <= IDLE;
            r_xc      <= '0;
            r_yc      <= '0;
            r_r       <= '0;
            r_x       <= '0;
`ifndef SET_FAST_SCAN_EN
            r_y       <= '0;
`endif
            r_acc     <= '0;
            r_hit     <= '0;
            r_flush   <= 1'b0;
            busy      <= 1'b0;
            valid     <= 1'b0;
            candidate <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    valid <= 1'b0;
                    busy  <= 1'b0;
                    if (en) begin
                        r_xc      <= central[7:4];
                        r_yc      <= central[3:0];
                        r_r       <= radius;
                        r_x       <= 4'd1;
`ifndef SET_FAST_SCAN_EN
                        r_y       <= 4'd1;
`endif
                        r_acc     <= '0;
                        r_hit     <= '0;
                        r_flush   <= 1'b0;
                        candidate <= '0;
                        busy      <= 1'b1;
                        r_state   <= CALC;
                    end
                end
                CALC: begin
                    r_acc <= r_acc + r_hit;
                    if (r_flush) begin
                        candidate <= r_acc + r_hit;
                        valid     <= 1'b1;
                        r_state   <= DONE;
                    end else begin
                        r_hit <= w_hit;
`ifdef SET_FAST_SCAN_EN
                        if (r_x == LAST) begin
                            r_flush <= 1'b1;
                        end else begin
                            r_x <= r_x + 4'd1;
                        end
`else
                        if (r_y == LAST) begin
                            r_y <= 4'd1;
                            if (r_x == LAST) begin
                                r_flush <= 1'b1;
                            end else begin
                                r_x <= r_x + 4'd1;
                            end
                        end else begin
                            r_y <= r_y + 4'd1;
                        end
`endif
                    end
                end
                DONE: begin
                    valid   <= 1'b0;
                    busy    <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_set_point_counter.sv
// Directed and randomised checks of set_point_counter: counts, latency, handshake,
// mid-job en and mid-job reset.
module tb_set_point_counter;

    localparam int G = 8;
`ifdef SET_FAST_SCAN_EN
    localparam int EXP_LAT = G + 1;
`else
    localparam int EXP_LAT = G * G + 1;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b0;
    logic [7:0] central = '0;
    logic [3:0] radius = '0;
    logic       busy;
    logic       valid;
    logic [7:0] candidate;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    set_point_counter #(.GRID_SIZE(G)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .central   (central),
        .radius    (radius),
        .busy      (busy),
        .valid     (valid),
        .candidate (candidate)
    );

    typedef struct {
        logic [7:0] c;
        logic [3:0] r;
        int         exp;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int model(input logic [7:0] c, input logic [3:0] r);
        int xc, yc, rr, cnt;
        xc  = int'(c[7:4]);
        yc  = int'(c[3:0]);
        rr  = int'(r);
        cnt = 0;
        for (int x = 1; x <= G; x++)
            for (int y = 1; y <= G; y++)
                if ((x - xc) * (x - xc) + (y - yc) * (y - yc) <= rr * rr) cnt++;
        return cnt;
    endfunction

    // Called at posedge+1; returns at posedge+1 just after the acceptance edge.
    task automatic start_job(input logic [7:0] c, input logic [3:0] r);
        int k;
        k = 0;
        while (busy && k < 500) begin
            @(posedge clk); #1;
            k++;
        end
        if (busy) check("idle_timeout", 1, 0);
        central = c;
        radius  = r;
        en      = 1'b1;
        @(posedge clk); #1;
        en = 1'b0;
    endtask

    task automatic wait_valid(output int lat, output int cand);
        lat  = -1;
        cand = -1;
        for (int n = 1; n <= 300; n++) begin
            @(posedge clk); #1;
            if (valid) begin
                lat  = n;
                cand = int'(candidate);
                break;
            end
        end
        if (lat < 0) check("valid_timeout", 0, 1);
    endtask

    task automatic run_job(input logic [7:0] c, input logic [3:0] r, input int exp);
        int lat, cand, b;
        start_job(c, r);
        check("busy_after_accept", int'(busy), 1);
        check("cand_cleared", int'(candidate), 0);
        wait_valid(lat, cand);
        b = int'(busy);
        check("candidate", cand, exp);
        check("latency", lat, EXP_LAT);
        check("busy_at_valid", b, 1);
        @(posedge clk); #1;
        check("valid_pulse_end", int'(valid), 0);
        check("busy_fall", int'(busy), 0);
        $display("job central=%02h radius=%0d candidate=%0d expected=%0d latency=%0d",
                 c, r, cand, exp, lat);
    endtask

    initial begin
        int lat, cand, pulses, hold_ok;
        logic [7:0] rc;
        logic [3:0] rr;

        vecs[0] = '{8'h44, 4'd2,  13};
        vecs[1] = '{8'h11, 4'd1,  3};
        vecs[2] = '{8'h44, 4'd0,  1};
        vecs[3] = '{8'h44, 4'd15, 64};
        vecs[4] = '{8'h00, 4'd0,  0};
        vecs[5] = '{8'h44, 4'd1,  5};
        vecs[6] = '{8'h88, 4'd1,  3};
        vecs[7] = '{8'h99, 4'd2,  1};

        // Reset held for three edges
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        check("reset_busy", int'(busy), 0);
        check("reset_valid", int'(valid), 0);
        check("reset_candidate", int'(candidate), 0);
        pulses = 0;
        repeat (10) begin
            @(posedge clk); #1;
            if (valid || busy) pulses++;
        end
        check("no_activity_without_en", pulses, 0);

        for (int i = 0; i < 8; i++) begin
            run_job(vecs[i].c, vecs[i].r, vecs[i].exp);
        end

        // en pulse with new operands while busy must be ignored
        start_job(8'h44, 4'd2);
        repeat (3) begin
            @(posedge clk); #1;
        end
        central = 8'h11;
        radius  = 4'd15;
        en      = 1'b1;
        @(posedge clk); #1;
        en = 1'b0;
        check("busy_ignores_en", int'(busy), 1);
        wait_valid(lat, cand);
        check("midjob_en_candidate", cand, 13);
        check("midjob_en_latency", lat, EXP_LAT - 4);
        $display("job central=44 radius=2 (en ignored mid-job) candidate=%0d latency=%0d", cand, lat);
        hold_ok = 1;
        repeat (6) begin
            @(posedge clk); #1;
            if (candidate != 8'd13 || valid) hold_ok = 0;
        end
        check("candidate_hold", hold_ok, 1);
        run_job(8'h11, 4'd1, 3);

        // Reset in the middle of CALC aborts the job
        start_job(8'h44, 4'd15);
        repeat (3) begin
            @(posedge clk); #1;
        end
        rst = 1'b0;
        @(posedge clk); #1;
        check("midreset_busy", int'(busy), 0);
        check("midreset_valid", int'(valid), 0);
        check("midreset_candidate", int'(candidate), 0);
        rst = 1'b1;
        run_job(8'h44, 4'd1, 5);

        // Back-to-back random jobs against the software model
        for (int j = 0; j < 64; j++) begin
            rc = 8'($urandom_range(0, 255));
            rr = 4'($urandom_range(0, 15));
            run_job(rc, rr, model(rc, rr));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
